pbs_damage_datapath: RTL and testbench



---
 rtl/pbs_pkg.sv | 25 ++
 rtl/pbs_damage_datapath_if.sv | 38 +++
 rtl/pbs_lfsr8.sv | 22 ++
 rtl/pbs_damage_datapath.sv | 134 +++++++++++++
 tb/tb_pbs_damage_datapath.sv | 289 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/pbs_pkg.sv
// Shared constants for the Pokemon battle system.
// Holds the move effectiveness encoding, the target / trainer select
// encodings shared with the battle control FSM, and the LFSR feedback mask.
package pbs_pkg;

   // Effectiveness of a move against the defending Pokemon
   typedef enum logic [1:0] {
      EFF_NONE   = 2'd0,
      EFF_HALF   = 2'd1,
      EFF_NORMAL = 2'd2,
      EFF_DOUBLE = 2'd3
   } eff_e;

   // target input: which Pokemon the current move is aimed at
   localparam logic TARGET_P   = 1'b0;
   localparam logic TARGET_AI  = 1'b1;

   // active_trainer input: whose turn it is
   localparam logic TRAINER_P  = 1'b0;
   localparam logic TRAINER_AI = 1'b1;

   // Right-shifting Galois mask for x^8 + x^6 + x^5 + x^4 + 1 (maximal length)
   localparam logic [7:0] LFSR_POLY = 8'hB8;

endpackage

// File: rtl/pbs_damage_datapath_if.sv
// Bus between the battle control FSM (master) and the damage datapath (slave).
// Requests : active_trainer, target, apply_ai_damage, apply_p_damage,
//            load_ai_hp / ai_hp_in, move power and effectiveness of both sides.
// Status   : p_hp, ai_hp, p_dead, ai_dead, protocol_err.
interface pbs_damage_datapath_if #(
   parameter int HP_W  = 8,
   parameter int POW_W = 8
);
   logic             active_trainer;
   logic             target;
   logic             apply_ai_damage;
   logic             apply_p_damage;
   logic             load_ai_hp;
   logic [HP_W-1:0]  ai_hp_in;
   logic [POW_W-1:0] p_move_power;
   logic [POW_W-1:0] ai_move_power;
   logic [1:0]       p_move_eff;
   logic [1:0]       ai_move_eff;
   logic [HP_W-1:0]  p_hp;
   logic [HP_W-1:0]  ai_hp;
   logic             p_dead;
   logic             ai_dead;
   logic             protocol_err;

   modport master (
      output active_trainer, target, apply_ai_damage, apply_p_damage,
             load_ai_hp, ai_hp_in, p_move_power, ai_move_power,
             p_move_eff, ai_move_eff,
      input  p_hp, ai_hp, p_dead, ai_dead, protocol_err
   );

   modport slave (
      input  active_trainer, target, apply_ai_damage, apply_p_damage,
             load_ai_hp, ai_hp_in, p_move_power, ai_move_power,
             p_move_eff, ai_move_eff,
      output p_hp, ai_hp, p_dead, ai_dead, protocol_err
   );
endinterface

// File: rtl/pbs_lfsr8.sv
// Free-running 8-bit Galois LFSR used as the damage random factor source.
// Ports: clk, reset_n (async, active-low), lfsr (current 8-bit state).
// A zero seed would lock the register at 0, so it is replaced by 8'h01.
module pbs_lfsr8
   import pbs_pkg::*;
#(
   parameter logic [7:0] SEED = 8'hA5
) (
   input  logic       clk,
   input  logic       reset_n,
   output logic [7:0] lfsr
);

   localparam logic [7:0] SEED_EFF = (SEED == 8'h00) ? 8'h01 : SEED;

   // Shift right every cycle; the bit falling out folds the feedback mask back in
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) lfsr <= SEED_EFF;
      else          lfsr <= {1'b0, lfsr[7:1]} ^ (lfsr[0] ? LFSR_POLY : 8'h00);
   end

endmodule

// File: rtl/pbs_damage_datapath.sv
// Battle damage datapath: holds both HP registers and applies move damage.
// Ports: clk, reset_n (async, active-low), bus (slave side of
// pbs_damage_datapath_if: requests in, HP values and flags out).
// Pipeline: stage 0 qualifies the request and computes damage, stage 1
// registers it, the HP register update forms stage 2 (2-cycle latency).
module pbs_damage_datapath
   import pbs_pkg::*;
#(
   parameter int              HP_W        = 8,
   parameter int              POW_W       = 8,
   parameter logic [HP_W-1:0] P_START_HP  = HP_W'(100),
   parameter logic [HP_W-1:0] AI_START_HP = HP_W'(100),
   parameter logic [7:0]      LFSR_SEED   = 8'hA5,
   parameter bit              RAND_EN     = 1'b1
) (
   input  logic                  clk,
   input  logic                  reset_n,
   pbs_damage_datapath_if.slave  bus
);

   localparam int RAW_W  = POW_W + 1;
   localparam int PROD_W = RAW_W + 9;
   localparam int DMG_W  = PROD_W - 8;
   localparam logic [HP_W-1:0] HP_MAX = '1;

   logic [7:0]        lfsr;
   logic              ai_legal, p_legal, ai_go, p_go, req_err;
   logic [POW_W-1:0]  sel_power;
   logic [1:0]        sel_eff;
   logic [RAW_W-1:0]  raw;
   logic [8:0]        factor;
   logic [PROD_W-1:0] prod;
   logic [DMG_W-1:0]  dmg_full;
   logic [HP_W-1:0]   dmg;
   logic              s1_valid, s1_tgt;
   logic [HP_W-1:0]   s1_dmg;
   logic [HP_W-1:0]   hp_src, hp_new;
   logic [HP_W-1:0]   p_hp_q, ai_hp_q;
   logic              p_dead_q, ai_dead_q, err_q;
   logic              lfsr_unused;

   pbs_lfsr8 #(.SEED(LFSR_SEED)) u_lfsr (
      .clk     (clk),
      .reset_n (reset_n),
      .lfsr    (lfsr)
   );

   // Only the low five LFSR bits and the top product bits feed the datapath
   assign lfsr_unused = &{1'b0, lfsr, prod[7:0]};

   // Request qualification. When both applies fire, the AI request wins and
   // the player request counts as illegal. A load in the same cycle voids
   // any damage aimed at the outgoing AI Pokemon.
   always_comb begin
      ai_legal = bus.apply_ai_damage && (bus.target == TARGET_AI)
                 && (bus.active_trainer == TRAINER_P);
      p_legal  = bus.apply_p_damage && !bus.apply_ai_damage
                 && (bus.target == TARGET_P) && (bus.active_trainer == TRAINER_AI);
      req_err  = (bus.apply_ai_damage && !ai_legal) || (bus.apply_p_damage && !p_legal);
      ai_go    = ai_legal && !ai_dead_q && !bus.load_ai_hp;
      p_go     = p_legal && !p_dead_q;
   end

   // Damage: the player's move hits the AI and vice versa. The 9-bit factor
   // is a fraction of 256, so the product is shifted down by 8. A landed move
   // always does at least 1 point; the result saturates at the HP width.
   always_comb begin
      sel_power = bus.apply_ai_damage ? bus.p_move_power : bus.ai_move_power;
      sel_eff   = bus.apply_ai_damage ? bus.p_move_eff   : bus.ai_move_eff;
      case (sel_eff)
         EFF_NONE:   raw = '0;
         EFF_HALF:   raw = {1'b0, sel_power} >> 1;
         EFF_NORMAL: raw = {1'b0, sel_power};
         default:    raw = {sel_power, 1'b0};
      endcase
      factor   = RAND_EN ? {4'b0111, lfsr[4:0]} : 9'd256;
      prod     = {9'd0, raw} * {{RAW_W{1'b0}}, factor};
      dmg_full = prod[PROD_W-1:8];
      if ((sel_eff != EFF_NONE) && (sel_power != '0) && (dmg_full == '0))
         dmg_full = DMG_W'(1);
      dmg = (32'(dmg_full) > 32'(HP_MAX)) ? HP_MAX : HP_W'(dmg_full);
   end

   // Stage 1 register: target select and damage of the qualified request
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         s1_valid <= 1'b0;
         s1_tgt   <= TARGET_P;
         s1_dmg   <= '0;
      end else begin
         s1_valid <= ai_go || p_go;
         s1_tgt   <= ai_go ? TARGET_AI : TARGET_P;
         s1_dmg   <= dmg;
      end
   end

   // Saturating subtract against whichever HP register stage 1 targets
   always_comb begin
      hp_src = (s1_tgt == TARGET_AI) ? ai_hp_q : p_hp_q;
      hp_new = (hp_src > s1_dmg) ? (hp_src - s1_dmg) : '0;
   end

   // Stage 2: HP and flag update. Loading a new AI Pokemon overrides any
   // damage landing on the AI in the same cycle; player HP is independent.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         p_hp_q    <= P_START_HP;
         ai_hp_q   <= AI_START_HP;
         p_dead_q  <= 1'b0;
         ai_dead_q <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         if (bus.load_ai_hp) begin
            ai_hp_q   <= bus.ai_hp_in;
            ai_dead_q <= (bus.ai_hp_in == '0);
         end else if (s1_valid && (s1_tgt == TARGET_AI)) begin
            ai_hp_q <= hp_new;
            if (hp_new == '0) ai_dead_q <= 1'b1;
         end
         if (s1_valid && (s1_tgt == TARGET_P)) begin
            p_hp_q <= hp_new;
            if (hp_new == '0) p_dead_q <= 1'b1;
         end
         if (req_err) err_q <= 1'b1;
      end
   end

   assign bus.p_hp         = p_hp_q;
   assign bus.ai_hp        = ai_hp_q;
   assign bus.p_dead       = p_dead_q;
   assign bus.ai_dead      = ai_dead_q;
   assign bus.protocol_err = err_q;

endmodule

// File: tb/tb_pbs_damage_datapath.sv
// Self-checking bench for pbs_damage_datapath.
// dut0 runs with RAND_EN=0 (exact damage) and is tracked by an arithmetic
// reference model; dut1 runs with RAND_EN=1 and is checked against the
// damage range the random factor allows.
module tb_pbs_damage_datapath;
   import pbs_pkg::*;

   logic clk;
   logic reset_n;
   int   tests = 0;
   int   fails = 0;

   // Reference model state, index 0 = dut0, 1 = dut1 (dut1: flags only)
   int m_p[2];
   int m_ai[2];
   bit m_pd[2];
   bit m_aid[2];
   bit m_err[2];

   pbs_damage_datapath_if #(.HP_W(8), .POW_W(8)) bus0 ();
   pbs_damage_datapath_if #(.HP_W(8), .POW_W(8)) bus1 ();

   pbs_damage_datapath #(
      .HP_W(8), .POW_W(8), .P_START_HP(8'd100), .AI_START_HP(8'd100),
      .LFSR_SEED(8'hA5), .RAND_EN(1'b0)
   ) dut0 (.clk(clk), .reset_n(reset_n), .bus(bus0));

   pbs_damage_datapath #(
      .HP_W(8), .POW_W(8), .P_START_HP(8'd100), .AI_START_HP(8'd100),
      .LFSR_SEED(8'h00), .RAND_EN(1'b1)
   ) dut1 (.clk(clk), .reset_n(reset_n), .bus(bus1));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Damage straight from the game rules: effectiveness scaling, factor/256,
   // minimum 1 for a landed move, capped at 255
   function automatic int modelDamage(input int power, input int eff, input int fac);
      int raw;
      int d;
      case (eff)
         0:       raw = 0;
         1:       raw = power / 2;
         2:       raw = power;
         default: raw = power * 2;
      endcase
      d = (raw * fac) / 256;
      if (eff != 0 && power != 0 && d == 0) d = 1;
      if (d > 255) d = 255;
      return d;
   endfunction

   task automatic modelRequest(input int s, input bit a_ai, input bit a_p, input bit tgt,
                               input bit trn, input int pp, input int pe, input int ap, input int ae);
      bit ai_ok;
      bit p_ok;
      int d;
      ai_ok = (tgt == 1'b1) && (trn == 1'b0);
      p_ok  = (tgt == 1'b0) && (trn == 1'b1);
      if ((a_ai && !ai_ok) || (a_p && !p_ok) || (a_ai && a_p)) m_err[s] = 1'b1;
      if (s == 0) begin
         if (a_ai) begin
            if (ai_ok && !m_aid[0]) begin
               d = modelDamage(pp, pe, 256);
               m_ai[0] = (m_ai[0] > d) ? m_ai[0] - d : 0;
               if (m_ai[0] == 0) m_aid[0] = 1'b1;
            end
         end else if (a_p) begin
            if (p_ok && !m_pd[0]) begin
               d = modelDamage(ap, ae, 256);
               m_p[0] = (m_p[0] > d) ? m_p[0] - d : 0;
               if (m_p[0] == 0) m_pd[0] = 1'b1;
            end
         end
      end
   endtask

   task automatic driveReq(input int s, input bit a_ai, input bit a_p, input bit tgt,
                           input bit trn, input int pp, input int pe, input int ap, input int ae);
      if (s == 0) begin
         bus0.apply_ai_damage = a_ai;  bus0.apply_p_damage = a_p;
         bus0.target = tgt;            bus0.active_trainer = trn;
         bus0.p_move_power = 8'(pp);   bus0.p_move_eff = 2'(pe);
         bus0.ai_move_power = 8'(ap);  bus0.ai_move_eff = 2'(ae);
      end else begin
         bus1.apply_ai_damage = a_ai;  bus1.apply_p_damage = a_p;
         bus1.target = tgt;            bus1.active_trainer = trn;
         bus1.p_move_power = 8'(pp);   bus1.p_move_eff = 2'(pe);
         bus1.ai_move_power = 8'(ap);  bus1.ai_move_eff = 2'(ae);
      end
      modelRequest(s, a_ai, a_p, tgt, trn, pp, pe, ap, ae);
   endtask

   task automatic clearReq(input int s);
      if (s == 0) begin
         bus0.apply_ai_damage = 1'b0; bus0.apply_p_damage = 1'b0; bus0.load_ai_hp = 1'b0;
      end else begin
         bus1.apply_ai_damage = 1'b0; bus1.apply_p_damage = 1'b0; bus1.load_ai_hp = 1'b0;
      end
   endtask

   // One-cycle request pulse; returns just after the edge that samples it
   task automatic applyStimulus(input int s, input bit a_ai, input bit a_p, input bit tgt,
                                input bit trn, input int pp, input int pe, input int ap, input int ae);
      driveReq(s, a_ai, a_p, tgt, trn, pp, pe, ap, ae);
      tick();
      clearReq(s);
   endtask

   task automatic loadAi(input int s, input int v);
      if (s == 0) begin bus0.load_ai_hp = 1'b1; bus0.ai_hp_in = 8'(v); end
      else        begin bus1.load_ai_hp = 1'b1; bus1.ai_hp_in = 8'(v); end
      m_ai[s]  = v;
      m_aid[s] = (v == 0);
      tick();
      clearReq(s);
   endtask

   task automatic checkState(input string tag);
      checkOutput({tag, " p_hp"},    bus0.p_hp,         m_p[0]);
      checkOutput({tag, " ai_hp"},   bus0.ai_hp,        m_ai[0]);
      checkOutput({tag, " p_dead"},  bus0.p_dead,       m_pd[0]);
      checkOutput({tag, " ai_dead"}, bus0.ai_dead,      m_aid[0]);
      checkOutput({tag, " err"},     bus0.protocol_err, m_err[0]);
   endtask

   // Player move into the AI on dut0, with a check that nothing lands early
   task automatic hitAi(input int pow, input int eff);
      int old_ai;
      old_ai = m_ai[0];
      applyStimulus(0, 1'b1, 1'b0, 1'b1, 1'b0, pow, eff, 7, 3);
      checkOutput("ai_hp latency", bus0.ai_hp, old_ai);
      tick();
   endtask

   initial begin
      int lo;
      int hi;
      int dmg;
      int first_dmg;
      int kind;
      int pp, pe, ap, ae;
      bit varied;

      reset_n = 1'b1;
      clearReq(0); clearReq(1);
      bus0.ai_hp_in = '0; bus1.ai_hp_in = '0;
      driveReq(0, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 0, 0);
      driveReq(1, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 0, 0);
      for (int s = 0; s < 2; s++) begin
         m_p[s] = 100; m_ai[s] = 100; m_pd[s] = 0; m_aid[s] = 0; m_err[s] = 0;
      end
      #2 reset_n = 1'b0;
      repeat (3) tick();

      // Reset values on both instances
      checkState("reset");
      checkOutput("reset dut1 p_hp",  bus1.p_hp, 100);
      checkOutput("reset dut1 ai_hp", bus1.ai_hp, 100);
      checkOutput("reset dut1 flags", {bus1.p_dead, bus1.ai_dead, bus1.protocol_err}, 0);

      @(negedge clk) reset_n = 1'b1;
      repeat (10) tick();
      checkOutput("idle p_hp", bus0.p_hp, 100);
      checkOutput("idle ai_hp", bus0.ai_hp, 100);
      checkState("idle");

      // Effectiveness scaling, exact damage
      hitAi(40, 2); checkOutput("eff2 ai_hp", bus0.ai_hp, 60); checkState("eff2");
      loadAi(0, 100);
      hitAi(40, 3); checkOutput("eff3 ai_hp", bus0.ai_hp, 20); checkState("eff3");
      loadAi(0, 100);
      hitAi(40, 1); checkOutput("eff1 ai_hp", bus0.ai_hp, 80); checkState("eff1");
      loadAi(0, 100);
      hitAi(40, 0); checkOutput("eff0 ai_hp", bus0.ai_hp, 100); checkState("eff0");

      // Back-to-back AI-then-player requests
      loadAi(0, 100);
      driveReq(0, 1'b1, 1'b0, 1'b1, 1'b0, 30, 2, 9, 1);
      tick();
      driveReq(0, 1'b0, 1'b1, 1'b0, 1'b1, 11, 3, 25, 2);
      tick();
      clearReq(0);
      checkOutput("b2b ai_hp N+2", bus0.ai_hp, 70);
      checkOutput("b2b p_hp N+2", bus0.p_hp, 100);
      tick();
      checkOutput("b2b p_hp N+3", bus0.p_hp, 75);
      checkState("b2b");

      // Kill the AI, then a request against the dead AI is silently dropped
      loadAi(0, 10);
      hitAi(50, 3);
      checkOutput("kill ai_hp", bus0.ai_hp, 0);
      checkOutput("kill ai_dead", bus0.ai_dead, 1);
      applyStimulus(0, 1'b1, 1'b0, 1'b1, 1'b0, 50, 2, 7, 3);
      tick();
      checkOutput("dead drop ai_hp", bus0.ai_hp, 0);
      checkOutput("dead drop err", bus0.protocol_err, 0);

      // Both applies together: AI side served, error raised
      loadAi(0, 100);
      checkOutput("reload ai_dead", bus0.ai_dead, 0);
      applyStimulus(0, 1'b1, 1'b1, 1'b1, 1'b0, 40, 2, 25, 2);
      tick();
      checkOutput("both ai_hp", bus0.ai_hp, 60);
      checkOutput("both p_hp", bus0.p_hp, 75);
      checkOutput("both err", bus0.protocol_err, 1);
      checkState("both");

      // Wrong target on dut1: dropped, error raised
      applyStimulus(1, 1'b1, 1'b0, 1'b0, 1'b0, 40, 2, 7, 3);
      tick();
      checkOutput("badtgt ai_hp", bus1.ai_hp, 100);
      checkOutput("badtgt err", bus1.protocol_err, m_err[1]);

      // Load one cycle after the request cancels the in-flight damage
      loadAi(0, 100);
      applyStimulus(0, 1'b1, 1'b0, 1'b1, 1'b0, 40, 2, 7, 3);
      loadAi(0, 55);
      checkOutput("cancel ai_hp", bus0.ai_hp, 55);
      checkOutput("cancel ai_dead", bus0.ai_dead, 0);
      tick();
      checkOutput("cancel ai_hp later", bus0.ai_hp, 55);

      // Saturation at 255 and the minimum-1 rule
      loadAi(0, 255);
      hitAi(200, 3); checkOutput("sat ai_hp", bus0.ai_hp, 0); checkState("sat");
      loadAi(0, 50);
      hitAi(1, 1); checkOutput("min1 ai_hp", bus0.ai_hp, 49); checkState("min1");

      // Random factor bounds on dut1
      lo = modelDamage(100, 2, 224);
      hi = modelDamage(100, 2, 255);
      varied = 1'b0;
      first_dmg = -1;
      for (int t = 0; t < 200; t++) begin
         loadAi(1, 200);
         applyStimulus(1, 1'b1, 1'b0, 1'b1, 1'b0, 100, 2, $urandom_range(0, 255), $urandom_range(0, 3));
         tick();
         dmg = 200 - int'(bus1.ai_hp);
         checkOutput("rand dmg in range", (dmg >= lo) && (dmg <= hi), 1);
         if (first_dmg < 0) first_dmg = dmg;
         else if (dmg != first_dmg) varied = 1'b1;
      end
      checkOutput("rand dmg varies", varied, 1);

      // Randomized mix on dut0 against the model
      for (int t = 0; t < 60; t++) begin
         kind = $urandom_range(0, 5);
         pp = $urandom_range(0, 255); pe = $urandom_range(0, 3);
         ap = $urandom_range(0, 255); ae = $urandom_range(0, 3);
         case (kind)
            0:       loadAi(0, $urandom_range(0, 255));
            1, 2:    applyStimulus(0, 1'b1, 1'b0, 1'b1, 1'b0, pp, pe, ap, ae);
            3, 4:    applyStimulus(0, 1'b0, 1'b1, 1'b0, 1'b1, pp, pe, ap, ae);
            default: applyStimulus(0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                                   1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                                   pp, pe, ap, ae);
         endcase
         tick();
         checkState("random");
      end

      // Player knockout sticks
      applyStimulus(0, 1'b0, 1'b1, 1'b0, 1'b1, 5, 1, 255, 3);
      tick();
      checkOutput("p knockout p_hp", bus0.p_hp, 0);
      checkOutput("p knockout p_dead", bus0.p_dead, 1);
      repeat (3) tick();
      checkOutput("p_dead sticky", bus0.p_dead, 1);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
